// File: rtl/tracker_pkg.sv
// Shared types and frame geometry for the tracker datapath: template layout, capture FSM
// states and the origin clamp used to place the template inside the frame.
package tracker_pkg;
    localparam int VGA_W    = 640;
    localparam int VGA_H    = 480;
    localparam int TPL_W    = 16;
    localparam int PIX_W    = 4;
    localparam int CNT_W    = $clog2(TPL_W);
    localparam int ADDR_W   = 19;
    localparam int TPL_BITS = TPL_W * TPL_W * PIX_W;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef pixel_t [TPL_W-1:0][TPL_W-1:0] template_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_ISSUE,
        ST_DRAIN,
        ST_COMMIT
    } cap_state_t;

    // Top-left corner of a template centred on 'centre', kept fully inside [0, limit].
    function automatic logic [9:0] clamp_origin(input logic [9:0] centre, input logic [9:0] limit);
        logic signed [10:0] diff;
        logic [9:0]         res;
        diff = $signed({1'b0, centre}) - $signed(11'(TPL_W / 2));
        if (diff < 0)
            res = '0;
        else if (diff > $signed({1'b0, limit}))
            res = limit;
        else
            res = diff[9:0];
        return res;
    endfunction
endpackage

// File: rtl/bram_read_pipe.sv
// Tag delay line matching BRAM read latency: {valid,tag} emerges RD_LAT cycles after push.
// No backpressure; flush clears all in-flight entries so their data is never claimed.
module bram_read_pipe #(
    parameter int RD_LAT = 2,
    parameter int TAG_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [TAG_W-1:0] push_tag,
    output logic             ret_vld,
    output logic [TAG_W-1:0] ret_tag
);
    logic [RD_LAT-1:0] vld_sr;
    logic [TAG_W-1:0]  tag_sr [RD_LAT];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            vld_sr <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_sr[i] <= '0;
        end else begin
            vld_sr[0] <= push_vld;
            tag_sr[0] <= push_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                tag_sr[i] <= tag_sr[i-1];
            end
        end
    end

    assign ret_vld = vld_sr[RD_LAT-1];
    assign ret_tag = tag_sr[RD_LAT-1];
endmodule

// File: rtl/template_capture.sv
// Reads a TPL_W x TPL_W window from the static frame BRAM into a shadow buffer and commits it
// atomically; commit lands TPL_W*TPL_W + RD_LAT + 3 cycles after the request when the frame is stable.
module template_capture
    import tracker_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                capture_req,
    input  logic [9:0]          c_x,
    input  logic [9:0]          c_y,
    input  logic                frame_rdy,
    output logic                bram_rd_en,
    output logic [ADDR_W-1:0]   bram_addr,
    input  logic [PIX_W-1:0]    bram_data,
    output logic [TPL_BITS-1:0] template_reg,
    output logic                template_valid,
    output logic                template_upd,
    output logic                busy
);
    localparam int TAG_W = 2 * CNT_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TPL_W - 1);

    cap_state_t        state, state_nxt;
    logic [CNT_W-1:0]  row, col;
    logic [9:0]        x0, y0;
    logic [TAG_W-1:0]  rd_tag;
    logic              issue, abort;
    logic              ret_vld;
    logic [TAG_W-1:0]  ret_tag;
    logic [ADDR_W-1:0] addr_calc;
    template_t         shadow, tpl_q;

    assign addr_calc = (ADDR_W'(y0) + ADDR_W'(row)) * ADDR_W'(VGA_W) + ADDR_W'(x0) + ADDR_W'(col);

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        abort     = 1'b0;
        unique case (state)
            ST_IDLE:     if (capture_req) state_nxt = ST_WAIT_RDY;
            ST_WAIT_RDY: if (frame_rdy) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (!frame_rdy) begin
                    abort     = 1'b1;
                    state_nxt = ST_WAIT_RDY;
                end else begin
                    issue = 1'b1;
                    if (row == LAST && col == LAST) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!frame_rdy) begin
                    abort     = 1'b1;
                    state_nxt = ST_WAIT_RDY;
                end else if (ret_vld && ret_tag == {LAST, LAST}) begin
                    state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT:   state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            row            <= '0;
            col            <= '0;
            x0             <= '0;
            y0             <= '0;
            bram_rd_en     <= 1'b0;
            bram_addr      <= '0;
            rd_tag         <= '0;
            tpl_q          <= '0;
            template_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            bram_rd_en <= issue;
            if (state == ST_IDLE && capture_req) begin
                x0 <= clamp_origin(c_x, 10'(VGA_W - TPL_W));
                y0 <= clamp_origin(c_y, 10'(VGA_H - TPL_W));
            end
            // Any cycle without an issue (idle, waiting, aborted) rewinds the raster to (0,0).
            if (issue) begin
                bram_addr <= addr_calc;
                rd_tag    <= {row, col};
                col       <= col + 1'b1;
                if (col == LAST) row <= row + 1'b1;
            end else begin
                row <= '0;
                col <= '0;
            end
            if (state == ST_COMMIT) begin
                tpl_q          <= shadow;
                template_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ret_vld) shadow[ret_tag[TAG_W-1:CNT_W]][ret_tag[CNT_W-1:0]] <= bram_data;
    end

    bram_read_pipe #(
        .RD_LAT (RD_LAT),
        .TAG_W  (TAG_W)
    ) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (abort),
        .push_vld (bram_rd_en),
        .push_tag (rd_tag),
        .ret_vld  (ret_vld),
        .ret_tag  (ret_tag)
    );

    assign template_reg = tpl_q;
    assign template_upd = (state == ST_COMMIT);
    assign busy         = (state != ST_IDLE);
endmodule

// File: tb/tb_template_capture.sv
// Bench for template_capture: BRAM model with pixel(x,y)=(x+y)%16 and a stability-window model
// of the capture (commit after the frame has stayed ready long enough since the request).
module tb_template_capture;
    import tracker_pkg::*;

    localparam int RD_LAT = 2;
    localparam int NPIX   = TPL_W * TPL_W;
    localparam int NEED   = NPIX + RD_LAT + 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                capture_req = 1'b0;
    logic [9:0]          c_x = '0, c_y = '0;
    logic                frame_rdy = 1'b1;
    logic                bram_rd_en;
    logic [ADDR_W-1:0]   bram_addr;
    logic [PIX_W-1:0]    bram_data = '0;
    logic [TPL_BITS-1:0] template_reg;
    logic                template_valid, template_upd, busy;

    template_capture #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .capture_req(capture_req), .c_x(c_x), .c_y(c_y),
        .frame_rdy(frame_rdy), .bram_rd_en(bram_rd_en), .bram_addr(bram_addr),
        .bram_data(bram_data), .template_reg(template_reg), .template_valid(template_valid),
        .template_upd(template_upd), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0, cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [TPL_BITS-1:0] act, input logic [TPL_BITS-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [PIX_W-1:0] pix_of(input logic [ADDR_W-1:0] a);
        int x, y;
        x = int'(a) % VGA_W;
        y = int'(a) / VGA_W;
        return PIX_W'((x + y) % 16);
    endfunction

    function automatic logic [TPL_BITS-1:0] tpl_of(input int x0, input int y0);
        logic [TPL_BITS-1:0] v;
        v = '0;
        for (int r = 0; r < TPL_W; r++)
            for (int c = 0; c < TPL_W; c++)
                v[(r*TPL_W+c)*PIX_W +: PIX_W] = PIX_W'((x0 + c + y0 + r) % 16);
        return v;
    endfunction

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int tpix(input int r, input int c);
        return int'(template_reg[(r*TPL_W+c)*PIX_W +: PIX_W]);
    endfunction

    // BRAM: data for the read launched RD_LAT cycles ago, garbage otherwise.
    logic              hist_vld  [RD_LAT+1];
    logic [ADDR_W-1:0] hist_addr [RD_LAT+1];
    always @(posedge clk) begin
        #1;
        for (int i = RD_LAT; i > 0; i--) begin
            hist_vld[i]  = hist_vld[i-1];
            hist_addr[i] = hist_addr[i-1];
        end
        hist_vld[0]  = bram_rd_en;
        hist_addr[0] = bram_addr;
        if (hist_vld[RD_LAT] === 1'b1) bram_data = pix_of(hist_addr[RD_LAT]);
        else bram_data = PIX_W'($urandom);
    end

    // Model: a capture finishes once frame_rdy has been high NEED consecutive cycles after the
    // request; the k-th read of a pass appears once the run is k+2 cycles long.
    bit  m_pend = 0, m_valid = 0, chk_en = 0;
    int  m_cnt = 0, m_x0 = 0, m_y0 = 0;
    logic [TPL_BITS-1:0] m_tpl = '0;
    bit  e_upd = 0, e_busy = 0, e_rd = 0, e_addr_chk = 0;
    int  e_addr = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pend = 0; m_cnt = 0; m_valid = 0; m_tpl = '0;
            e_upd = 0; e_busy = 0; e_rd = 0; e_addr = 0; e_addr_chk = 1; chk_en = 1;
        end else begin
            e_addr_chk = 0;
            if (e_upd) begin
                m_tpl = tpl_of(m_x0, m_y0); m_valid = 1; m_pend = 0;
            end else if (m_pend) begin
                m_cnt = frame_rdy ? m_cnt + 1 : 0;
            end else if (capture_req) begin
                m_pend = 1; m_cnt = 0;
                m_x0 = clampi(int'(c_x) - TPL_W/2, VGA_W - TPL_W);
                m_y0 = clampi(int'(c_y) - TPL_W/2, VGA_H - TPL_W);
            end
            e_busy = m_pend;
            e_upd  = m_pend && (m_cnt == NEED);
            e_rd   = m_pend && (m_cnt >= 2) && (m_cnt <= NPIX + 1);
            if (e_rd) begin
                e_addr = (m_y0 + (m_cnt - 2) / TPL_W) * VGA_W + m_x0 + (m_cnt - 2) % TPL_W;
                e_addr_chk = 1;
            end
        end
    end

    logic [ADDR_W-1:0] rd_log[$];
    int upd_cnt = 0, upd_cyc = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", int'(busy), int'(e_busy));
            chk("template_upd", int'(template_upd), int'(e_upd));
            chk("template_valid", int'(template_valid), int'(m_valid));
            chk("bram_rd_en", int'(bram_rd_en), int'(e_rd));
            if (e_addr_chk) chk("bram_addr", int'(bram_addr), e_addr);
            chk_vec("template_reg", template_reg, m_tpl);
        end
        if (template_upd === 1'b1) begin upd_cnt++; upd_cyc = cyc; end
        if (bram_rd_en === 1'b1) rd_log.push_back(bram_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input int cx, input int cy, output int rcyc);
        c_x = 10'(cx); c_y = 10'(cy); capture_req = 1'b1; rcyc = cyc;
        tick();
        capture_req = 1'b0;
    endtask

    task automatic wait_upd(input int n0, input string nm);
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            tick();
            if (upd_cnt > n0) ok = 1;
        end
        if (!ok) begin n_cmp++; n_err++; $display("FAIL %s_timeout: no template_upd within 3000 cycles", nm); end
    endtask

    task automatic wait_reads(input int target, input string nm);
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            tick();
            if (rd_log.size() >= target) ok = 1;
        end
        if (!ok) begin n_cmp++; n_err++; $display("FAIL %s_timeout: reads %0d < %0d", nm, rd_log.size(), target); end
    endtask

    function automatic int log_at(input int idx);
        if (idx >= 0 && idx < rd_log.size()) return int'(rd_log[idx]);
        return -1;
    endfunction

    initial begin
        int rc, rb, n0, nr, drop_left;
        logic [TPL_BITS-1:0] saved;

        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(template_valid), 0);
        chk("rst_rd_en", int'(bram_rd_en), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // 1: centred capture
        n0 = upd_cnt; rb = rd_log.size();
        start_req(320, 240, rc);
        wait_upd(n0, "t1");
        chk("t1_latency", upd_cyc - rc, 261);
        chk("t1_first_addr", log_at(rb), 148792);
        chk("t1_reads", rd_log.size() - rb, 256);
        chk("t1_busy_after", int'(busy), 0);
        chk("t1_valid", int'(template_valid), 1);
        chk("t1_pix_0_0", tpix(0, 0), (544 + 0 + 0) % 16);
        chk("t1_pix_15_15", tpix(15, 15), (544 + 15 + 15) % 16);
        chk("t1_pix_3_7", tpix(3, 7), (544 + 3 + 7) % 16);
        repeat (3) tick();

        // 2: clamp at top-left
        n0 = upd_cnt; rb = rd_log.size();
        start_req(3, 5, rc);
        wait_upd(n0, "t2");
        chk("t2_first_addr", log_at(rb), 0);
        chk("t2_last_addr", log_at(rd_log.size() - 1), 9615);
        chk("t2_pix_2_9", tpix(2, 9), 11);
        repeat (3) tick();

        // 3: clamp at bottom-right
        n0 = upd_cnt; rb = rd_log.size();
        start_req(639, 479, rc);
        wait_upd(n0, "t3");
        chk("t3_first_addr", log_at(rb), 297584);
        chk("t3_last_addr", log_at(rd_log.size() - 1), 307199);
        repeat (3) tick();

        // 4: frame not ready at the request
        frame_rdy = 1'b0;
        n0 = upd_cnt; rb = rd_log.size();
        start_req(100, 50, rc);
        repeat (50) tick();
        chk("t4_no_reads_while_unready", rd_log.size() - rb, 0);
        frame_rdy = 1'b1;
        wait_upd(n0, "t4");
        chk("t4_latency", upd_cyc - rc, 311);
        chk("t4_first_addr", log_at(rb), 26972);
        repeat (3) tick();

        // 4b: frame drops mid-capture, restart from (0,0)
        n0 = upd_cnt; rb = rd_log.size();
        start_req(200, 100, rc);
        wait_reads(rb + 100, "t4b_reads");
        frame_rdy = 1'b0;
        saved = template_reg;
        repeat (10) tick();
        chk_vec("t4b_tpl_held", template_reg, saved);
        frame_rdy = 1'b1;
        nr = rd_log.size();
        wait_reads(nr + 1, "t4b_restart");
        chk("t4b_restart_addr", log_at(nr), 59072);
        wait_upd(n0, "t4b");
        chk("t4b_reads_after_restart", rd_log.size() - nr, 256);
        repeat (3) tick();

        // 5: second request during ISSUE is dropped
        n0 = upd_cnt; rb = rd_log.size();
        start_req(320, 240, rc);
        wait_reads(rb + 20, "t5_reads");
        start_req(10, 10, rc);
        wait_upd(n0, "t5");
        repeat (5) tick();
        chk("t5_reads", rd_log.size() - rb, 256);
        chk("t5_upd_once", upd_cnt - n0, 1);

        // 5b: reset mid-capture
        rb = rd_log.size();
        start_req(50, 60, rc);
        wait_reads(rb + 128, "t5b_reads");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5b_busy", int'(busy), 0);
        chk("t5b_valid", int'(template_valid), 0);
        chk("t5b_upd", int'(template_upd), 0);
        chk("t5b_rd_en", int'(bram_rd_en), 0);
        chk("t5b_addr", int'(bram_addr), 0);
        chk_vec("t5b_tpl", template_reg, '0);
        n0 = upd_cnt;
        repeat (300) tick();
        chk("t5b_no_upd", upd_cnt - n0, 0);

        // back-to-back captures of the same image
        n0 = upd_cnt;
        start_req(400, 300, rc);
        wait_upd(n0, "b2b_1");
        saved = template_reg;
        start_req(400, 300, rc);
        wait_upd(n0 + 1, "b2b_2");
        chk_vec("b2b_same_tpl", template_reg, saved);
        chk("b2b_upd_twice", upd_cnt - n0, 2);
        chk("b2b_valid", int'(template_valid), 1);

        // randomized requests and frame_rdy glitches
        drop_left = 0;
        for (int i = 0; i < 8000; i++) begin
            capture_req = ($urandom_range(0, 60) == 0);
            if (capture_req) begin
                c_x = 10'($urandom_range(0, 1023));
                c_y = 10'($urandom_range(0, 1023));
            end
            if (drop_left > 0) begin
                drop_left--;
                frame_rdy = (drop_left == 0);
            end else if ($urandom_range(0, 700) == 0) begin
                frame_rdy = 1'b0;
                drop_left = $urandom_range(1, 20);
            end
            tick();
        end
        capture_req = 1'b0;
        frame_rdy = 1'b1;
        repeat (400) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
